// File: rtl/exec_controller.sv
`default_nettype none
// ============================================================================
//  Module      : exec_controller
//  Description : Run-control sequencer between the JTAG register bank and the
//                processing core. Turns level start/step bits into run, step
//                and pause sequencing, drives the core clock-enable and a
//                one-cycle clear, latches the run mode and keeps a saturating
//                enabled-cycle counter with an optional watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_controller #(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             mode,
    input  logic             core_done,
    output logic             core_en,
    output logic             core_clr,
    output logic             mode_q,
    output logic             busy,
    output logic             done_flag,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] perf_counter
);

    localparam logic [CNT_W-1:0] C_WDOG_LIMIT = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_start_q;
    logic             r_step_q;
    logic             r_go_run;
    logic             w_go_run_next;
    logic             w_start_re;
    logic             w_step_re;
    logic             w_wdog_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    // Rising-edge detection so that held levels never retrigger
    assign w_start_re = start & ~r_start_q;
    assign w_step_re  = step  & ~r_step_q;

    // Saturating increment: the counter sticks at all-ones
    assign w_cnt_inc  = (&perf_counter) ? perf_counter : perf_counter + C_ONE;

    // Watchdog compares against the count this cycle will produce
    assign w_wdog_hit = (WDOG_LIMIT != 0) && (w_cnt_inc == C_WDOG_LIMIT);

    // Next-state selection; start edges take priority over step edges
    always_comb begin
        w_state_next  = r_state;
        w_go_run_next = r_go_run;
        case (r_state)
            ST_IDLE: begin
                if (w_start_re) begin
                    w_state_next  = ST_CLEAR;
                    w_go_run_next = 1'b1;
                end else if (w_step_re) begin
                    w_state_next  = ST_CLEAR;
                    w_go_run_next = 1'b0;
                end
            end
            ST_CLEAR: w_state_next = r_go_run ? ST_RUN : ST_STEP;
            ST_RUN: begin
                if (core_done)       w_state_next = ST_DONE;
                else if (w_wdog_hit) w_state_next = ST_DONE;
                else if (w_step_re)  w_state_next = ST_PAUSE;
            end
            ST_STEP:  w_state_next = core_done ? ST_DONE : ST_PAUSE;
            ST_PAUSE: begin
                if (w_start_re)     w_state_next = ST_RUN;
                else if (w_step_re) w_state_next = ST_STEP;
            end
            ST_DONE: begin
                if (w_start_re) begin
                    w_state_next  = ST_CLEAR;
                    w_go_run_next = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b0;
            r_step_q     <= 1'b0;
            r_go_run     <= 1'b0;
            core_en      <= 1'b0;
            core_clr     <= 1'b0;
            busy         <= 1'b0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            mode_q       <= 1'b0;
            perf_counter <= '0;
        end else begin
            r_start_q <= start;
            r_step_q  <= step;
            r_state   <= w_state_next;
            r_go_run  <= w_go_run_next;
            core_en   <= (w_state_next == ST_RUN) || (w_state_next == ST_STEP);
            core_clr  <= (w_state_next == ST_CLEAR);
            busy      <= (w_state_next == ST_CLEAR) || (w_state_next == ST_RUN) ||
                         (w_state_next == ST_STEP);
            done_flag <= (w_state_next == ST_DONE);

            if (r_state == ST_CLEAR) begin
                perf_counter <= '0;
                mode_q       <= mode;
            end else if ((r_state == ST_RUN) || (r_state == ST_STEP)) begin
                perf_counter <= w_cnt_inc;
            end

            // Timeout is only visible while parked in DONE after a watchdog exit
            if (w_state_next != ST_DONE)
                timeout_flag <= 1'b0;
            else if ((r_state == ST_RUN) && !core_done && w_wdog_hit)
                timeout_flag <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_controller
//  Description : Self-checking bench for exec_controller. Two instances (32-bit
//                counter with watchdog 16, 4-bit counter without watchdog) share
//                stimulus and are compared every cycle with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_controller;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RUN   = 2;
    localparam int M_STEP  = 3;
    localparam int M_PAUSE = 4;
    localparam int M_DONE  = 5;

    localparam longint A_MAX  = 64'h0000_0000_FFFF_FFFF;
    localparam longint A_WDOG = 16;
    localparam longint B_MAX  = 15;
    localparam longint B_WDOG = 0;

    typedef struct packed {
        int     st;
        logic   go;
        logic   mq;
        logic   tmo;
        logic   sq;
        logic   pq;
        longint cnt;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst, start, step, mode, core_done;
    logic        a_en, a_clr, a_mq, a_busy, a_done, a_tmo;
    logic [31:0] a_cnt;
    logic        b_en, b_clr, b_mq, b_busy, b_done, b_tmo;
    logic [3:0]  b_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    exec_controller #(.CNT_W(32), .WDOG_LIMIT(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .step(step), .mode(mode),
        .core_done(core_done), .core_en(a_en), .core_clr(a_clr), .mode_q(a_mq),
        .busy(a_busy), .done_flag(a_done), .timeout_flag(a_tmo), .perf_counter(a_cnt)
    );

    exec_controller #(.CNT_W(4), .WDOG_LIMIT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .step(step), .mode(mode),
        .core_done(core_done), .core_en(b_en), .core_clr(b_clr), .mode_q(b_mq),
        .busy(b_busy), .done_flag(b_done), .timeout_flag(b_tmo), .perf_counter(b_cnt)
    );

    // Behavioural reference: one clock edge of the run-control rules
    function automatic mdl_t advance(input mdl_t m, input logic s, input logic p,
                                     input logic md, input logic cd,
                                     input longint cmax, input longint wdog);
        mdl_t   n   = m;
        logic   sre = s & ~m.sq;
        logic   pre = p & ~m.pq;
        longint inc = (m.cnt >= cmax) ? cmax : m.cnt + 1;
        n.sq = s;
        n.pq = p;
        case (m.st)
            M_IDLE:  if (sre) begin n.st = M_CLEAR; n.go = 1'b1; end
                     else if (pre) begin n.st = M_CLEAR; n.go = 1'b0; end
            M_CLEAR: begin n.cnt = 0; n.mq = md; n.st = m.go ? M_RUN : M_STEP; end
            M_RUN: begin
                n.cnt = inc;
                if (cd) n.st = M_DONE;
                else if (wdog != 0 && inc == wdog) begin n.st = M_DONE; n.tmo = 1'b1; end
                else if (pre) n.st = M_PAUSE;
            end
            M_STEP:  begin n.cnt = inc; n.st = cd ? M_DONE : M_PAUSE; end
            M_PAUSE: if (sre) n.st = M_RUN; else if (pre) n.st = M_STEP;
            M_DONE:  if (sre) begin n.st = M_CLEAR; n.go = 1'b1; end
            default: n.st = M_IDLE;
        endcase
        if (n.st != M_DONE) n.tmo = 1'b0;
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input mdl_t m, input logic en, input logic clr,
                             input logic mq, input logic bsy, input logic dn, input logic tmo,
                             input logic [63:0] cnt);
        check({nm, ".core_en"},      64'(en),  64'(m.st == M_RUN || m.st == M_STEP));
        check({nm, ".core_clr"},     64'(clr), 64'(m.st == M_CLEAR));
        check({nm, ".mode_q"},       64'(mq),  64'(m.mq));
        check({nm, ".busy"},         64'(bsy), 64'(m.st == M_CLEAR || m.st == M_RUN || m.st == M_STEP));
        check({nm, ".done_flag"},    64'(dn),  64'(m.st == M_DONE));
        check({nm, ".timeout_flag"}, 64'(tmo), 64'(m.tmo));
        check({nm, ".perf_counter"}, cnt,      64'(m.cnt));
    endtask

    task automatic compare_all();
        check_dut("a", ma, a_en, a_clr, a_mq, a_busy, a_done, a_tmo, 64'(a_cnt));
        check_dut("b", mb, b_en, b_clr, b_mq, b_busy, b_done, b_tmo, 64'(b_cnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        ma = advance(ma, start, step, mode, core_done, A_MAX, A_WDOG);
        mb = advance(mb, start, step, mode, core_done, B_MAX, B_WDOG);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; step = 1'b0; core_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ma = '0;
        mb = '0;
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; mode = 1'b0; core_done = 1'b0;
        ma = '0; mb = '0;
        do_reset();

        // Plain run in SIMD mode, core finishes on the 10th enabled cycle
        mode  = 1'b1;
        start = 1'b1;
        cycle();
        check("t1.clr", 64'(a_clr), 64'd1);
        cycle();
        mode = 1'b0;
        repeat (9) cycle();
        core_done = 1'b1;
        cycle();
        core_done = 1'b0;
        check("t1.count", 64'(a_cnt), 64'd10);
        check("t1.mode_q", 64'(a_mq), 64'd1);
        check("t1.done", 64'(a_done), 64'd1);

        // Held start does not restart; a fresh edge does
        repeat (5) cycle();
        check("t2.hold_done", 64'(a_done), 64'd1);
        start = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        check("t2.clr", 64'(a_clr), 64'd1);
        cycle();
        check("t2.count0", 64'(a_cnt), 64'd0);
        core_done = 1'b1;
        cycle();
        core_done = 1'b0;

        // Single stepping from IDLE, then resume without clear
        do_reset();
        step = 1'b1;
        cycle(); cycle(); cycle();
        for (int i = 0; i < 2; i++) begin
            step = 1'b0; cycle();
            step = 1'b1; cycle(); cycle();
        end
        step = 1'b0;
        check("t3.count", 64'(a_cnt), 64'd3);
        check("t3.paused", 64'(a_busy), 64'd0);
        start = 1'b1;
        cycle();
        check("t3.resume_en", 64'(a_en), 64'd1);
        check("t3.no_clr", 64'(a_clr), 64'd0);

        // Step edge together with core_done ends the run
        step = 1'b1; core_done = 1'b1;
        cycle();
        step = 1'b0; core_done = 1'b0;
        check("t4.done", 64'(a_done), 64'd1);

        // Watchdog on instance a, saturation on instance b
        start = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        repeat (17) cycle();
        check("t5.wdog_done", 64'(a_done), 64'd1);
        check("t5.wdog_flag", 64'(a_tmo), 64'd1);
        check("t5.wdog_count", 64'(a_cnt), 64'd16);
        repeat (20) cycle();
        check("t5.sat_count", 64'(b_cnt), 64'd15);
        check("t5.sat_busy", 64'(b_busy), 64'd1);

        // Asynchronous reset in the middle of a run
        do_reset();
        start = 1'b1;
        cycle(); cycle();
        repeat (7) cycle();
        check("t6.count7", 64'(a_cnt), 64'd7);
        #2 rst = 1'b1;
        #1;
        check("t6.async_en", 64'(a_en), 64'd0);
        check("t6.async_cnt", 64'(a_cnt), 64'd0);
        check("t6.async_clr", 64'(a_clr), 64'd0);
        ma = '0; mb = '0;
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        check("t6.idle", 64'(a_busy), 64'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) start = ~start;
            if ($urandom_range(0, 7) == 0) step  = ~step;
            mode      = 1'($urandom_range(0, 1));
            core_done = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
